// File: rtl/wf8_regbus_pkg.sv
// Shared types and constants for the register-bank sequencer.
package wf8_regbus_pkg;

    // Sequencer states: latch a command, drive the bank for one cycle, then turn the bus around.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Requester identifiers, used as the grant index.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    // One-hot per-requester vector selecting the given requester.
    function automatic logic [1:0] req_onehot(input logic idx);
        return (idx == REQ_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted winner.
module rr_arbiter2
    import wf8_regbus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_winner;

    // Pick the winner: a lone request wins, a tie goes to whoever lost last time.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        grant_valid = |req;
        grant_idx   = REQ_CORE;
        case (req)
            2'b10:   grant_idx = REQ_DBG;
            2'b11:   grant_idx = ~last_winner;
            default: grant_idx = REQ_CORE;
        endcase
    end

    // Advance the pointer only when the grant is actually taken by the sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Pretending the debug port won last makes the core the first tie winner.
            last_winner <= REQ_DBG;
        end else if (accept && grant_valid) begin
            last_winner <= grant_idx;
        end
    end

endmodule

// File: rtl/regbank_ctrl.sv
// Sequencer for a bank of enable-gated registers sharing a write bus and a read bus.
module regbank_ctrl
    import wf8_regbus_pkg::*;
#(
    parameter int BIT_COUNT = 8,
    parameter int REG_COUNT = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [BIT_COUNT-1:0] wdata0,
    input  logic [BIT_COUNT-1:0] wdata1,
    output logic [1:0]           done,
    output logic [1:0]           err,
    output logic [BIT_COUNT-1:0] rdata,
    output logic [REG_COUNT-1:0] reg_write_en,
    output logic [REG_COUNT-1:0] reg_read_en,
    output logic [BIT_COUNT-1:0] reg_in,
    input  logic [BIT_COUNT-1:0] reg_out
);

    state_t               state;
    logic                 winner;
    logic                 lat_err;
    logic                 lat_rd;

    logic                 grant_valid;
    logic                 grant_idx;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [BIT_COUNT-1:0] sel_wdata;
    logic                 in_range;
    logic [REG_COUNT-1:0] dec;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .accept      (state == IDLE),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Route the granted requester's command and decode its address to a one-hot select.
    always_comb begin
        sel_we    = we[grant_idx];
        sel_addr  = (grant_idx == REQ_DBG) ? addr1 : addr0;
        sel_wdata = (grant_idx == REQ_DBG) ? wdata1 : wdata0;
        in_range  = int'(sel_addr) < REG_COUNT;
        dec       = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            dec[i] = (int'(sel_addr) == i);
        end
    end

    // Sequencer: every output is registered, so enables depend only on latched state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            // NOTE: the whole control path is reset (no storage array here), so a dropped transaction leaves nothing behind.
            state        <= IDLE;
            winner       <= REQ_CORE;
            lat_err      <= 1'b0;
            lat_rd       <= 1'b0;
            done         <= '0;
            err          <= '0;
            rdata        <= '0;
            reg_write_en <= '0;
            reg_read_en  <= '0;
            reg_in       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner  <= grant_idx;
                        lat_err <= !in_range;
                        lat_rd  <= !sel_we && in_range;
                        if (sel_we) begin
                            reg_write_en <= dec;
                            reg_in       <= sel_wdata;
                        end else begin
                            reg_read_en  <= dec;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    reg_write_en <= '0;
                    reg_read_en  <= '0;
                    if (lat_rd) begin
                        rdata <= reg_out;
                    end
                    done  <= req_onehot(winner);
                    err   <= lat_err ? req_onehot(winner) : 2'b00;
                    state <= DONE;
                end
                DONE: begin
                    // Enables are already low here, giving the bus its turnaround cycle.
                    done  <= '0;
                    err   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed and random-traffic bench for regbank_ctrl with a behavioural register bank.
module tb_regbank_ctrl;

    localparam int BW = 8;
    localparam int RC = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = '0;
    logic [1:0]    we = '0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [BW-1:0] wdata0 = '0;
    logic [BW-1:0] wdata1 = '0;
    logic [1:0]    done;
    logic [1:0]    err;
    logic [BW-1:0] rdata;
    logic [RC-1:0] reg_write_en;
    logic [RC-1:0] reg_read_en;
    logic [BW-1:0] reg_in;
    logic [BW-1:0] reg_out;

    logic [BW-1:0] bank [RC];

    int checks = 0;
    int fails  = 0;

    // Random-phase requester bookkeeping and expected-value model.
    logic [1:0]    pend = '0;
    logic [1:0]    pwe = '0;
    logic [AW-1:0] paddr [2];
    logic [BW-1:0] pdata [2];
    logic [BW-1:0] shadow [RC];
    logic [BW-1:0] exp_rdata;
    int            issued = 0;
    int            completed = 0;

    regbank_ctrl #(.BIT_COUNT(BW), .REG_COUNT(RC), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en),
        .reg_in       (reg_in),
        .reg_out      (reg_out)
    );

    always #5 clk = ~clk;

    // Register bank: capture the write bus when enabled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RC; i++) begin
            if (reg_write_en[i]) bank[i] <= reg_in;
        end
    end

    // Read bus: only the enabled register drives it.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < RC; i++) begin
            if (reg_read_en[i]) reg_out = bank[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction from a single requester, with its completion checked.
    task automatic do_txn(input logic idx, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
        req      = '0;
        req[idx] = 1'b1;
        we[idx]  = w;
        if (idx) begin addr1 = a; wdata1 = d; end
        else     begin addr0 = a; wdata0 = d; end
        tick();
        tick();
        check("txn_done", done, idx ? 2'b10 : 2'b01);
        req = '0;
        tick();
    endtask

    // One random-phase cycle: invariant checks, completion scoring, optional new commands.
    task automatic step_random(input bit allow_issue);
        logic exp_err;
        tick();
        check("inv_wr_onehot", 32'($onehot0(reg_write_en)), 1);
        check("inv_rd_onehot", 32'($onehot0(reg_read_en)), 1);
        check("inv_no_contention", 32'((|reg_write_en) && (|reg_read_en)), 0);
        check("inv_done_single", 32'($onehot0(done)), 1);
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
                check("rnd_done_pending", 32'(pend[i]), 1);
                if (pend[i]) begin
                    exp_err = (paddr[i] >= AW'(RC));
                    if (!exp_err && pwe[i])  shadow[paddr[i][1:0]] = pdata[i];
                    if (!exp_err && !pwe[i]) exp_rdata = shadow[paddr[i][1:0]];
                    check("rnd_err", 32'(err[i]), 32'(exp_err));
                    check("rnd_rdata", 32'(rdata), 32'(exp_rdata));
                    completed++;
                    pend[i] = 1'b0;
                    req[i]  = 1'b0;
                end
            end
        end
        if (allow_issue) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pwe[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = AW'($urandom_range(0, 7));
                    pdata[i] = BW'($urandom);
                    we[i]    = pwe[i];
                    if (i == 0) begin addr0 = paddr[i]; wdata0 = pdata[i]; end
                    else        begin addr1 = paddr[i]; wdata1 = pdata[i]; end
                    req[i]   = 1'b1;
                    issued++;
                end
            end
        end
    endtask

    initial begin
        // Reset values.
        tick();
        tick();
        rst = 1'b0;
        check("rst_done", done, 2'b00);
        check("rst_err", err, 2'b00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_wen", reg_write_en, 4'b0000);
        check("rst_ren", reg_read_en, 4'b0000);
        check("rst_reg_in", reg_in, 8'h00);

        // Core writes A5 to register 2.
        req = 2'b01; we = 2'b01; addr0 = 3'd2; wdata0 = 8'hA5;
        tick();
        check("wr_wen_access", reg_write_en, 4'b0100);
        check("wr_reg_in", reg_in, 8'hA5);
        check("wr_done_early", done, 2'b00);
        tick();
        check("wr_done", done, 2'b01);
        check("wr_err", err, 2'b00);
        check("wr_wen_cleared", reg_write_en, 4'b0000);
        req = 2'b00;
        tick();
        check("wr_done_pulse", done, 2'b00);
        check("wr_bank", bank[2], 8'hA5);

        // Core reads register 2 back.
        req = 2'b01; we = 2'b00; addr0 = 3'd2;
        tick();
        check("rd_ren_access", reg_read_en, 4'b0100);
        check("rd_wen_idle", reg_write_en, 4'b0000);
        tick();
        check("rd_done", done, 2'b01);
        check("rd_rdata", rdata, 8'hA5);
        check("rd_ren_cleared", reg_read_en, 4'b0000);
        req = 2'b00;
        tick();

        // Debug port alone writes 3C to register 3; it becomes the last winner.
        req = 2'b10; we = 2'b10; addr1 = 3'd3; wdata1 = 8'h3C;
        tick();
        check("dbg_wen", reg_write_en, 4'b1000);
        tick();
        check("dbg_done", done, 2'b10);
        req = 2'b00;
        tick();

        // Contention: both hold writes; grants alternate core, debug, core, debug.
        req = 2'b11; we = 2'b11; addr0 = 3'd0; wdata0 = 8'h11; addr1 = 3'd1; wdata1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_wen", reg_write_en, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            check("rr_reg_in", reg_in, (k % 2 == 0) ? 8'h11 : 8'h22);
            tick();
            check("rr_done", done, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 3) req = 2'b00;
            tick();
            check("rr_gap", done, 2'b00);
        end

        // Out-of-range read: no enables, err flagged, rdata untouched.
        req = 2'b01; we = 2'b00; addr0 = 3'd5;
        tick();
        check("oor_wen", reg_write_en, 4'b0000);
        check("oor_ren", reg_read_en, 4'b0000);
        tick();
        check("oor_done", done, 2'b01);
        check("oor_err", err, 2'b01);
        check("oor_rdata", rdata, 8'hA5);
        req = 2'b00;
        tick();

        // Reset in ACCESS of a core write: transaction dropped, pointer back to core.
        req = 2'b01; we = 2'b01; addr0 = 3'd0; wdata0 = 8'h77;
        tick();
        check("rstmid_wen", reg_write_en, 4'b0001);
        rst = 1'b1; req = 2'b00;
        tick();
        check("rstmid_wen_cleared", reg_write_en, 4'b0000);
        check("rstmid_ren", reg_read_en, 4'b0000);
        check("rstmid_done", done, 2'b00);
        check("rstmid_rdata", rdata, 8'h00);
        check("rstmid_reg_in", reg_in, 8'h00);
        rst = 1'b0;
        tick();
        check("rstmid_no_done", done, 2'b00);
        req = 2'b11; we = 2'b00; addr0 = 3'd3; addr1 = 3'd1;
        tick();
        check("rstmid_core_first", reg_read_en, 4'b1000);
        tick();
        check("rstmid_rd_done", done, 2'b01);
        check("rstmid_rd_data", rdata, 8'h3C);
        req = 2'b00;
        tick();

        // Known contents for the random phase.
        do_txn(1'b0, 1'b1, 3'd0, 8'h5A);
        shadow[0] = 8'h5A;
        shadow[1] = 8'h22;
        shadow[2] = 8'hA5;
        shadow[3] = 8'h3C;
        exp_rdata = 8'h3C;

        // Random traffic with per-cycle invariants, then a bounded drain.
        for (int c = 0; c < 10000; c++) step_random(1'b1);
        for (int c = 0; c < 30 && pend != 2'b00; c++) step_random(1'b0);
        check("rnd_all_done", completed, issued);
        check("rnd_none_pending", pend, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
